// File: rtl/bus_mem_pkg.sv
// bus_mem_pkg: shared types, sizes and byte-lane helper for the bus memory responder
package bus_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACCEPT} state_t;
  localparam int MEM_WORDS = 4096;
  localparam int ADDR_LSB  = 2;
  localparam int ADDR_MSB  = 13;
  localparam int MAX_WAIT  = 18;
  localparam int CNT_W     = $clog2(MAX_WAIT + 1);
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    lane_merge = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) lane_merge[8*i +: 8] = new_w[8*i +: 8];
  endfunction
endpackage

// File: rtl/lfsr16_stall.sv
// lfsr16_stall: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) supplying 0-3 extra wait states
module lfsr16_stall #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] extra_wait
);
  logic [15:0] r_lfsr;
  always_ff @(posedge clk)
    if (reset) r_lfsr <= SEED;
    else       r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign extra_wait = r_lfsr[1:0];
endmodule

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: Avalon-style 4096-word RAM slave with programmable/random wait states
// and a sticky flag for initiator protocol violations.
module bus_mem_responder
  import bus_mem_pkg::*;
#(
  parameter string       RAM_INIT_FILE = "",
  parameter int          WAIT_CYCLES   = 0,
  parameter bit          RANDOM_STALL  = 1'b0,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        protocol_error
);
  localparam int IW = ADDR_MSB - ADDR_LSB + 1;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr, r_wdata, r_rdata;
  logic [3:0]       r_be;
  logic             r_we, r_perr;
  logic [31:0]      r_mem [MEM_WORDS];
  logic [1:0]       w_extra;
  logic [CNT_W-1:0] w_n;
  logic [IW-1:0]    w_idx;
  logic             w_idle, w_req, w_both, w_changed, w_done, w_viol;
  initial for (int i = 0; i < MEM_WORDS; i++) r_mem[i] = '0;
  lfsr16_stall #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .extra_wait(w_extra));
  assign w_n       = CNT_W'(WAIT_CYCLES) + (RANDOM_STALL ? {{(CNT_W-2){1'b0}}, w_extra} : '0);
  assign w_idx     = address[ADDR_MSB:ADDR_LSB];
  assign w_idle    = r_state != WAIT;
  assign w_req     = read ^ write;
  assign w_both    = read & write;
  // Any deviation from the request latched on entry counts as a withdrawal.
  assign w_changed = (read != !r_we) | (write != r_we) | (address != r_addr) |
                     (writedata != r_wdata) | (byteenable != r_be);
  // ACCEPT behaves like IDLE so a new request can follow an acceptance directly.
  assign w_done    = w_idle ? (w_req & (w_n == '0)) : (!w_changed & (r_cnt == '0));
  assign w_viol    = w_idle ? (w_both | (w_req & (address[1:0] != 2'b00))) : w_changed;
  assign waitrequest    = reset | !(w_done | (w_idle & w_both));
  assign readdata       = r_rdata;
  assign protocol_error = r_perr;
  always @(posedge clk)
    if (!reset && w_done && write) r_mem[w_idx] <= lane_merge(r_mem[w_idx], writedata, byteenable);
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_perr  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
    end else begin
      if (w_done && read) r_rdata <= r_mem[w_idx];
      if (w_viol) r_perr <= 1'b1;
      if (w_idle) begin
        r_state <= w_both ? IDLE : w_done ? ACCEPT : w_req ? WAIT : IDLE;
        if (w_req) begin
          r_addr  <= address;
          r_wdata <= writedata;
          r_be    <= byteenable;
          r_we    <= write;
          r_cnt   <= w_done ? '0 : w_n - CNT_W'(1);
        end
      end else begin
        r_state <= (w_changed || r_cnt == '0) ? IDLE : WAIT;
        r_cnt   <= (w_changed || r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder: self-checking bench over five responder configurations
module tb_bus_mem_responder;
  localparam int NI = 5;
  localparam int WC [NI] = '{0, 2, 3, 4, 1};
  localparam bit RS [NI] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] e;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst  [NI];
  logic        rd   [NI];
  logic        wr   [NI];
  logic        wreq [NI];
  logic        perr [NI];
  logic [31:0] addr [NI];
  logic [31:0] wdat [NI];
  logic [31:0] rdat [NI];
  logic [3:0]  be   [NI];
  logic [31:0] exp_q [$];
  vec_t        vt [14];
  int          tests = 0, fails = 0;
  int          w, varied;
  int          rws [2][100];
  logic [2:0]  pat;
  logic [31:0] last;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    bus_mem_responder #(.WAIT_CYCLES(WC[g]), .RANDOM_STALL(RS[g])) u_dut (
      .clk(clk), .reset(rst[g]), .address(addr[g]), .write(wr[g]), .read(rd[g]),
      .waitrequest(wreq[g]), .writedata(wdat[g]), .byteenable(be[g]),
      .readdata(rdat[g]), .protocol_error(perr[g]));
  end
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic xfer(input int i, input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output int waits);
    rd[i] = !we; wr[i] = we; addr[i] = a; wdat[i] = d; be[i] = b;
    waits = 0;
    @(negedge clk);
    while (wreq[i] === 1'b1 && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 40) check("xfer timeout", 32'(waits), 32'd0);
    @(posedge clk); #1;
    rd[i] = 1'b0; wr[i] = 1'b0;
  endtask
  task automatic rd_chk(input int i, input logic [31:0] a, input logic [31:0] e, input string n,
                        output int waits);
    exp_q.push_back(e);
    xfer(i, 1'b0, a, 32'h0, 4'hF, waits);
    check(n, rdat[i], exp_q.pop_front());
  endtask
  task automatic rand_run(input int run);
    int ww;
    logic [31:0] k8;
    rst[4] = 1'b1;
    @(posedge clk); #1;
    rst[4] = 1'b0;
    for (int k = 0; k < 8; k++) xfer(4, 1'b1, 32'h300 + 32'(k) * 4, 32'hD00D0000 + 32'(k), 4'hF, ww);
    for (int k = 0; k < 100; k++) begin
      k8 = 32'((k * 3) % 8);
      rd_chk(4, 32'h300 + k8 * 4, 32'hD00D0000 + k8, $sformatf("rand%0d read%0d", run, k), ww);
      rws[run][k] = ww;
      check($sformatf("rand%0d waits%0d in 1..4", run, k), 32'(ww >= 1 && ww <= 4), 32'd1);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    vt[0]  = '{1'b1, 32'hBFC00040, 32'h00000000, 4'hF, 32'h0};
    vt[1]  = '{1'b1, 32'hBFC00040, 32'hAABBCCDD, 4'h5, 32'h0};
    vt[2]  = '{1'b0, 32'hBFC00040, 32'h0,        4'hF, 32'h00BB00DD};
    vt[3]  = '{1'b1, 32'h00000044, 32'h11223344, 4'hF, 32'h0};
    vt[4]  = '{1'b1, 32'h00000044, 32'hFFFFFFFF, 4'h0, 32'h0};
    vt[5]  = '{1'b0, 32'h00000044, 32'h0,        4'hF, 32'h11223344};
    vt[6]  = '{1'b1, 32'h0000FFFC, 32'hCAFEF00D, 4'hF, 32'h0};
    vt[7]  = '{1'b1, 32'h00010000, 32'h0BADBEEF, 4'hF, 32'h0};
    vt[8]  = '{1'b0, 32'h00003FFC, 32'h0,        4'hF, 32'hCAFEF00D};
    vt[9]  = '{1'b0, 32'hBFC00000, 32'h0,        4'hF, 32'h0BADBEEF};
    vt[10] = '{1'b1, 32'h00000048, 32'h01020304, 4'hF, 32'h0};
    vt[11] = '{1'b0, 32'h00000048, 32'h0,        4'hF, 32'h01020304};
    vt[12] = '{1'b1, 32'h00000048, 32'hAB000000, 4'h8, 32'h0};
    vt[13] = '{1'b0, 32'h80000048, 32'h0,        4'hF, 32'hAB020304};
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdat[i] = '0; be[i] = '0;
    end
    rd[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset waitrequest dut%0d", i), 32'(wreq[i]), 32'd1);
      check($sformatf("reset readdata dut%0d", i), rdat[i], 32'd0);
      check($sformatf("reset protocol_error dut%0d", i), 32'(perr[i]), 32'd0);
    end
    @(posedge clk); #1;
    rd[0] = 1'b0;
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    last = 32'h0;
    for (int k = 0; k < 14; k++) begin
      if (vt[k].we) begin
        xfer(0, 1'b1, vt[k].a, vt[k].d, vt[k].b, w);
        check($sformatf("vec%0d readdata held", k), rdat[0], last);
      end else begin
        rd_chk(0, vt[k].a, vt[k].e, $sformatf("vec%0d readdata", k), w);
        last = vt[k].e;
      end
      check($sformatf("vec%0d waits", k), 32'(w), 32'd0);
    end
    check("w0 protocol_error clean", 32'(perr[0]), 32'd0);
    rd_chk(0, 32'h0000004A, 32'hAB020304, "misaligned readdata", w);
    check("misaligned protocol_error", 32'(perr[0]), 32'd1);
    xfer(1, 1'b1, 32'h80, 32'h11111111, 4'hF, w);
    check("w2 write waits", 32'(w), 32'd2);
    exp_q.push_back(32'h11111111);
    rd[1] = 1'b1; addr[1] = 32'h80; wdat[1] = 32'h0; be[1] = 4'hF;
    pat = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      pat = {pat[1:0], wreq[1]};
      if (c == 2) check("w2 readdata before accept", rdat[1], 32'h0);
      @(posedge clk); #1;
    end
    rd[1] = 1'b0;
    check("w2 waitrequest pattern", 32'(pat), 32'b110);
    check("w2 readdata", rdat[1], exp_q.pop_front());
    check("w2 protocol_error clean", 32'(perr[1]), 32'd0);
    rd[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h80; wdat[1] = 32'h22222222; be[1] = 4'hF;
    @(negedge clk);
    check("both-high waitrequest", 32'(wreq[1]), 32'd0);
    @(posedge clk); #1;
    rd[1] = 1'b0; wr[1] = 1'b0;
    check("both-high protocol_error", 32'(perr[1]), 32'd1);
    rd_chk(1, 32'h80, 32'h11111111, "both-high memory unchanged", w);
    check("w2 recovery waits", 32'(w), 32'd2);
    xfer(2, 1'b1, 32'h100, 32'h33333333, 4'hF, w);
    check("w3 write waits", 32'(w), 32'd3);
    rd[2] = 1'b1; addr[2] = 32'h100; wdat[2] = 32'h0; be[2] = 4'hF;
    @(posedge clk); #1;
    rd[2] = 1'b0;
    @(posedge clk); #1;
    check("dropped read protocol_error", 32'(perr[2]), 32'd1);
    check("dropped read readdata", rdat[2], 32'h0);
    wr[2] = 1'b1; addr[2] = 32'h100; wdat[2] = 32'h44444444; be[2] = 4'hF;
    @(posedge clk); #1;
    be[2] = 4'h1;
    @(posedge clk); #1;
    wr[2] = 1'b0;
    rd_chk(2, 32'h100, 32'h33333333, "withdrawn write no access", w);
    check("w3 after abort waits", 32'(w), 32'd3);
    xfer(3, 1'b1, 32'h202, 32'h0000AAAA, 4'hF, w);
    check("w4 misaligned protocol_error", 32'(perr[3]), 32'd1);
    wr[3] = 1'b1; addr[3] = 32'h200; wdat[3] = 32'h12345678; be[3] = 4'hF;
    @(posedge clk); #1;
    rst[3] = 1'b1;
    @(negedge clk);
    check("mid-wait reset waitrequest", 32'(wreq[3]), 32'd1);
    @(posedge clk); #1;
    rst[3] = 1'b0; wr[3] = 1'b0;
    check("mid-wait reset protocol_error", 32'(perr[3]), 32'd0);
    rd_chk(3, 32'h200, 32'h0000AAAA, "mid-wait reset memory unchanged", w);
    check("w4 read waits", 32'(w), 32'd4);
    rand_run(0);
    rand_run(1);
    varied = 0;
    for (int k = 0; k < 100; k++) begin
      check($sformatf("rand wait repeat%0d", k), 32'(rws[1][k]), 32'(rws[0][k]));
      if (rws[0][k] != rws[0][0]) varied = 1;
    end
    check("rand waits vary", 32'(varied), 32'd1);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
